// File: rtl/perf_pkg.sv
// Shared types for the perf_if counter protocol: counter word, controller
// command opcodes and controller FSM states.
package perf_pkg;

  typedef logic [31:0] counter_t;

  typedef enum logic [1:0] {
    PERF_OP_READ     = 2'd0,
    PERF_OP_CLEAR    = 2'd1,
    PERF_OP_TOGGLE   = 2'd2,
    PERF_OP_SNAPSHOT = 2'd3
  } perf_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    RESP  = 2'd2
  } perf_ctrl_state_t;

endpackage

// File: rtl/perf_snapshot_bank.sv
// Register bank holding a coherent copy of every slave counter.
// All entries are captured together on cap_en; rd_idx selects one entry,
// out-of-range indices read as zero.
module perf_snapshot_bank
  import perf_pkg::*;
#(
  parameter int unsigned PERF_REG_NUM = 4,
  parameter int unsigned IDX_W        = (PERF_REG_NUM > 1) ? $clog2(PERF_REG_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  counter_t         cap_data [PERF_REG_NUM],
  input  logic [IDX_W-1:0] rd_idx,
  output counter_t         rd_data
);

  counter_t bank [PERF_REG_NUM];

  // Capture all counters in one cycle so the copy is mutually consistent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PERF_REG_NUM; i++) bank[i] <= '0;
    end else if (cap_en) begin
      for (int unsigned i = 0; i < PERF_REG_NUM; i++) bank[i] <= cap_data[i];
    end
  end

  // Indexed read; compare against each entry so no index can fall off the array
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < PERF_REG_NUM; i++) begin
      if (32'(rd_idx) == i) rd_data = bank[i];
    end
  end

endmodule

// File: rtl/perf_ctrl_master.sv
// Master-side controller for the perf_if counter protocol. Turns single
// commands (READ/CLEAR/TOGGLE/SNAPSHOT) into trigger pulses or counter reads
// and returns one response per command.
// Optional feature macro: PERF_SNAPSHOT_EN (snapshot bank; READ returns bank).
module perf_ctrl_master
  import perf_pkg::*;
#(
  parameter int unsigned PERF_REG_NUM = 4,
  parameter int unsigned IDX_W        = (PERF_REG_NUM > 1) ? $clog2(PERF_REG_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  perf_op_t         cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output counter_t         rsp_data,
  output logic             rsp_err,
  output logic             counting_en,
  output logic             clear_trigger,
  output logic             toggle_trigger,
  input  counter_t         counter_r [PERF_REG_NUM]
);

  perf_ctrl_state_t state;
  counter_t         rd_val;
  logic             cmd_accept;
  logic             idx_ok;

  // Gated by rst so no command can be accepted while reset is held
  assign cmd_ready  = (state == IDLE) && !rst;
  assign cmd_accept = cmd_valid && cmd_ready;
  assign idx_ok     = 32'(cmd_idx) < PERF_REG_NUM;

`ifdef PERF_SNAPSHOT_EN
  localparam logic SNAP_ERR = 1'b0;

  perf_snapshot_bank #(
    .PERF_REG_NUM (PERF_REG_NUM),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cmd_accept && (cmd_op == PERF_OP_SNAPSHOT)),
    .cap_data (counter_r),
    .rd_idx   (cmd_idx),
    .rd_data  (rd_val)
  );
`else
  localparam logic SNAP_ERR = 1'b1;

  // Live counter select for READ when no bank is present
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < PERF_REG_NUM; i++) begin
      if (32'(cmd_idx) == i) rd_val = counter_r[i];
    end
  end
`endif

  // Command FSM with registered triggers and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      clear_trigger  <= 1'b0;
      toggle_trigger <= 1'b0;
      counting_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            case (cmd_op)
              PERF_OP_READ: begin
                rsp_valid <= 1'b1;
                rsp_err   <= !idx_ok;
                rsp_data  <= idx_ok ? rd_val : '0;
                state     <= RESP;
              end
              PERF_OP_CLEAR: begin
                clear_trigger <= 1'b1;
                state         <= PULSE;
              end
              PERF_OP_TOGGLE: begin
                toggle_trigger <= 1'b1;
                state          <= PULSE;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= SNAP_ERR;
                rsp_data  <= '0;
                state     <= RESP;
              end
            endcase
          end
        end
        PULSE: begin
          // The pulse register itself records which op is in flight
          if (toggle_trigger) counting_en <= !counting_en;
          clear_trigger  <= 1'b0;
          toggle_trigger <= 1'b0;
          rsp_valid      <= 1'b1;
          rsp_err        <= 1'b0;
          rsp_data       <= '0;
          state          <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perf_ctrl_master.sv
// Directed bench for perf_ctrl_master (PERF_REG_NUM=4, IDX_W widened to 3 so
// an out-of-range index can be driven).
module tb_perf_ctrl_master;
  import perf_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  perf_op_t       cmd_op;
  logic [IW-1:0]  cmd_idx;
  logic           rsp_valid;
  logic           rsp_ready;
  counter_t       rsp_data;
  logic           rsp_err;
  logic           counting_en;
  logic           clear_trigger;
  logic           toggle_trigger;
  counter_t       cr [N];

  int checks = 0;
  int errors = 0;

`ifdef PERF_SNAPSHOT_EN
  localparam logic     EXP_SNAP_ERR = 1'b0;
  localparam counter_t EXP_RD2      = 32'd7;
  localparam counter_t EXP_RD1      = 32'd6;
`else
  localparam logic     EXP_SNAP_ERR = 1'b1;
  localparam counter_t EXP_RD2      = 32'd9;
  localparam counter_t EXP_RD1      = 32'd9;
`endif

  always #5 clk = ~clk;

  perf_ctrl_master #(
    .PERF_REG_NUM (N),
    .IDX_W        (IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_idx        (cmd_idx),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .counting_en    (counting_en),
    .clear_trigger  (clear_trigger),
    .toggle_trigger (toggle_trigger),
    .counter_r      (cr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle; returns #1 after acceptance edge N (cycle N+1)
  task automatic issue(input perf_op_t op, input logic [IW-1:0] idx);
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Complete the response handshake and check the FSM returns to idle
  task automatic respond(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_rv_low"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = PERF_OP_READ;
    cmd_idx   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) cr[i] = '0;

    repeat (3) @(posedge clk);
    #1 chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rel_rsp_data", rsp_data, 32'd0);
    chk("rel_rsp_err", 32'(rsp_err), 32'd0);
    chk("rel_trig", {30'd0, clear_trigger, toggle_trigger}, 32'd0);
    chk("rel_cnt_en", 32'(counting_en), 32'd0);

    // TOGGLE: pulse in N+1 only, counting_en and rsp_valid from N+2
    @(posedge clk); #1;
    issue(PERF_OP_TOGGLE, '0);
    chk("tog_pulse", 32'(toggle_trigger), 32'd1);
    chk("tog_clr_low", 32'(clear_trigger), 32'd0);
    chk("tog_rv_n1", 32'(rsp_valid), 32'd0);
    chk("tog_en_n1", 32'(counting_en), 32'd0);
    chk("tog_busy", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("tog_pulse_end", 32'(toggle_trigger), 32'd0);
    chk("tog_en_n2", 32'(counting_en), 32'd1);
    chk("tog_rv_n2", 32'(rsp_valid), 32'd1);
    chk("tog_data", rsp_data, 32'd0);
    chk("tog_err", 32'(rsp_err), 32'd0);
    respond("tog");

    issue(PERF_OP_TOGGLE, '0);
    @(posedge clk); #1;
    chk("tog2_en", 32'(counting_en), 32'd0);
    respond("tog2");

    // SNAPSHOT then change live counters and READ
    cr[0] = 32'd5; cr[1] = 32'd6; cr[2] = 32'd7; cr[3] = 32'd8;
    issue(PERF_OP_SNAPSHOT, '0);
    chk("snap_rv", 32'(rsp_valid), 32'd1);
    chk("snap_err", 32'(rsp_err), 32'(EXP_SNAP_ERR));
    chk("snap_data", rsp_data, 32'd0);
    chk("snap_no_trig", {30'd0, clear_trigger, toggle_trigger}, 32'd0);
    respond("snap");
    for (int i = 0; i < N; i++) cr[i] = 32'd9;

    issue(PERF_OP_READ, 3'd2);
    chk("rd2_rv", 32'(rsp_valid), 32'd1);
    chk("rd2_data", rsp_data, EXP_RD2);
    chk("rd2_err", 32'(rsp_err), 32'd0);
    // Back-pressure: response held stable while rsp_ready is low
    cr[2] = 32'd123;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_rv", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, EXP_RD2);
      chk("hold_ready", 32'(cmd_ready), 32'd0);
    end
    respond("rd2");
    cr[2] = 32'd9;

    issue(PERF_OP_READ, 3'd1);
    chk("rd1_data", rsp_data, EXP_RD1);
    respond("rd1");

    cr[3] = 32'hFFFF_FFFF;
    issue(PERF_OP_READ, 3'd3);
`ifdef PERF_SNAPSHOT_EN
    chk("rd3_data", rsp_data, 32'd8);
`else
    chk("rd3_data", rsp_data, 32'hFFFF_FFFF);
`endif
    respond("rd3");

    // Out-of-range index
    issue(PERF_OP_READ, 3'd4);
    chk("oor_rv", 32'(rsp_valid), 32'd1);
    chk("oor_err", 32'(rsp_err), 32'd1);
    chk("oor_data", rsp_data, 32'd0);
    chk("oor_no_trig", {30'd0, clear_trigger, toggle_trigger}, 32'd0);
    respond("oor");

    // CLEAR keeps counting_en
    issue(PERF_OP_TOGGLE, '0);
    @(posedge clk); #1;
    respond("tog3");
    issue(PERF_OP_CLEAR, '0);
    chk("clr_pulse", 32'(clear_trigger), 32'd1);
    chk("clr_tog_low", 32'(toggle_trigger), 32'd0);
    @(posedge clk); #1;
    chk("clr_pulse_end", 32'(clear_trigger), 32'd0);
    chk("clr_rv", 32'(rsp_valid), 32'd1);
    chk("clr_en_kept", 32'(counting_en), 32'd1);
    respond("clr");

    // CLEAR aborted by reset during its pulse cycle
    issue(PERF_OP_CLEAR, '0);
    chk("abort_pulse", 32'(clear_trigger), 32'd1);
    #1 rst = 1'b1;
    #1 chk("abort_drop", 32'(clear_trigger), 32'd0);
    chk("abort_en_rst", 32'(counting_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("abort_ready", 32'(cmd_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_no_trig", {30'd0, clear_trigger, toggle_trigger}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global timeout so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/perf_ctrl_master.md
Name: perf_ctrl_master

Overview:
- Master-side controller for the perf_if counter protocol; drives clear_trigger/toggle_trigger and reads the slave's counter_r bank.
- Exposes a command/response handshake to the tile's config/debug path: clear, toggle (start/stop), snapshot, read one counter.
- Sits between the cohort config register path and one perf_if slave.

Parameters:
- PERF_REG_NUM, 4, number of counters in the slave bank (matches the perf_if perf_reg_num parameter).
- IDX_W, $clog2(PERF_REG_NUM) with a minimum of 1, width of the counter index field.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command request valid
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  perf_pkg::perf_op_t: 0 READ, 1 CLEAR, 2 TOGGLE, 3 SNAPSHOT
- cmd_idx  in  IDX_W  counter index; used only by READ
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  $bits(counter_t)  READ data; 0 for other ops and for errors
- rsp_err  out  1  index out of range, or unsupported op
- counting_en  out  1  shadow of the slave's counting state
- clear_trigger  out  1  perf_if master: one-cycle clear pulse
- toggle_trigger  out  1  perf_if master: one-cycle toggle pulse
- counter_r  in  counter_t[PERF_REG_NUM]  perf_if master: live counter values

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - cmd_ready=0 while rst is high; cmd_ready=1 in the first cycle after rst deasserts.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - clear_trigger=0, toggle_trigger=0, counting_en=0.
  - Snapshot bank cleared to 0.
- FSM states: IDLE, PULSE, RESP.
- cmd_ready=1 only in IDLE. A command is accepted on cmd_valid&&cmd_ready at edge N.
- READ:
  - idx<PERF_REG_NUM: rsp_data = selected counter, captured at edge N. The value is the snapshot bank entry (feature on) or counter_r live (feature off).
  - Transition IDLE->RESP. rsp_valid=1 from cycle N+1.
- CLEAR or TOGGLE:
  - IDLE->PULSE. The corresponding trigger is high for exactly cycle N+1.
  - TOGGLE flips counting_en at edge N+1.
  - PULSE->RESP: rsp_valid=1 from cycle N+2, rsp_data=0, rsp_err=0.
  - CLEAR does not change counting_en.
- SNAPSHOT:
  - All PERF_REG_NUM counters are copied into the bank at edge N in one cycle.
  - IDLE->RESP, rsp_valid from N+1, rsp_data=0.
- Error case (READ with idx>=PERF_REG_NUM):
  - IDLE->RESP, rsp_err=1, rsp_data=0.
  - No trigger pulse and no state change.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: RESP->IDLE, rsp_valid=0 next cycle. cmd_ready returns to 1 the cycle after the handshake.
- Only one command is outstanding at a time; there is no pipelining.
- At most one trigger is high in any cycle, and never for two consecutive cycles.
- Reset mid-operation aborts the operation:
  - A pending pulse is dropped, and a pulse in flight is forced low.
  - No response is produced for the aborted command.
- counter_r is sampled only at capture edges; counter wrap-around is the slave's concern and is passed through unmodified.

Optional Feature:
- Macro PERF_SNAPSHOT_EN.
- Defined:
  - SNAPSHOT op and the bank exist.
  - READ returns bank contents, giving a coherent multi-counter view.
- Undefined:
  - No bank registers.
  - READ returns counter_r[idx] captured at acceptance.
  - SNAPSHOT responds with rsp_err=1, rsp_data=0 and has no side effects.

Decomposition:
- perf_pkg holds:
  - counter_t (existing).
  - perf_op_t enum: PERF_OP_READ, PERF_OP_CLEAR, PERF_OP_TOGGLE, PERF_OP_SNAPSHOT.
  - perf_ctrl_state_t enum: IDLE, PULSE, RESP.
- One sub-module, perf_snapshot_bank:
  - Parameterised register array with capture enable and indexed read.
  - Instantiated only under PERF_SNAPSHOT_EN.

Test Plan:
- Reset release with idle inputs -> cmd_ready=1 in the first cycle after rst deasserts; all other outputs 0; counting_en=0.
- TOGGLE accepted at cycle 10 -> toggle_trigger=1 in cycle 11 only; counting_en=1 from cycle 12; rsp_valid from cycle 12. A second TOGGLE -> counting_en=0.
- counter_r={5,6,7,8}, SNAPSHOT, then counter_r changed to {9,9,9,9}, READ idx=2 -> rsp_data=7 with feature on; 9 with feature off, where SNAPSHOT also returns rsp_err=1.
- READ idx=4 with PERF_REG_NUM=4 -> rsp_err=1, rsp_data=0, no trigger pulse.
- rsp_ready held low for 5 cycles after a READ -> rsp_valid and rsp_data stable, cmd_ready=0 throughout. rsp_ready=1 -> cmd_ready=1 the next cycle.
- CLEAR accepted, then rst asserted during the pulse cycle -> clear_trigger drops immediately; no rsp_valid after rst releases.
